// File: rtl/load_store_unit.sv
// Core-side load/store initiator for a byte-addressed, big-endian data memory.
// Uses a 4-state FSM; sub-word stores are handled as a read-modify-write of the containing word.
module load_store_unit #(
  parameter int MEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_fault,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic        mem_memwrite,
  input  logic [31:0] mem_read_data
);
  localparam logic [1:0] IDLE = 2'd0, READ = 2'd1, WRITE = 2'd2, RESP = 2'd3;

  logic [1:0]  state;
  logic        r_write, r_signed;
  logic [1:0]  r_size;
  logic [31:0] r_addr, r_wdata, word_reg;
  logic        hs, fault;
  logic [2:0]  nbytes;
  logic [32:0] last_byte;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] ld_ext, wmerge;

  assign req_ready = (state == IDLE) && !reset;
  assign hs        = req_valid && req_ready;

  // The last-byte sum is done in 33 bits so addresses near 2^32 cannot wrap into range.
  always_comb begin
    case (req_size)
      2'b00:   nbytes = 3'd1;
      2'b01:   nbytes = 3'd2;
      default: nbytes = 3'd4;
    endcase
    last_byte = {1'b0, req_addr} + {30'd0, nbytes} - 33'd1;
    fault = (req_size == 2'b11) ||
            (req_size == 2'b01 && req_addr[0]) ||
            (req_size == 2'b10 && req_addr[1:0] != 2'b00) ||
            (last_byte >= 33'(MEM_BYTES));
  end

  always_comb begin
    case (r_addr[1:0])
      2'd0:    lane_b = mem_read_data[31:24];
      2'd1:    lane_b = mem_read_data[23:16];
      2'd2:    lane_b = mem_read_data[15:8];
      default: lane_b = mem_read_data[7:0];
    endcase
    lane_h = r_addr[1] ? mem_read_data[15:0] : mem_read_data[31:16];
    case (r_size)
      2'b00:   ld_ext = {{24{r_signed & lane_b[7]}}, lane_b};
      2'b01:   ld_ext = {{16{r_signed & lane_h[15]}}, lane_h};
      default: ld_ext = mem_read_data;
    endcase
  end

  always_comb begin
    wmerge = word_reg;
    case (r_size)
      2'b00:
        case (r_addr[1:0])
          2'd0:    wmerge[31:24] = r_wdata[7:0];
          2'd1:    wmerge[23:16] = r_wdata[7:0];
          2'd2:    wmerge[15:8]  = r_wdata[7:0];
          default: wmerge[7:0]   = r_wdata[7:0];
        endcase
      2'b01:
        if (r_addr[1]) wmerge[15:0]  = r_wdata[15:0];
        else           wmerge[31:16] = r_wdata[15:0];
      default: wmerge = r_wdata;
    endcase
  end

  // Memory-side outputs decode from state; reset gates them so a store in flight is dropped.
  assign mem_memwrite   = (state == WRITE) && !reset;
  assign mem_write_data = mem_memwrite ? wmerge : 32'd0;
  assign mem_address    = ((state == READ || state == WRITE) && !reset) ? {r_addr[31:2], 2'b00} : 32'd0;
  assign resp_valid     = (state == RESP) && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      r_write    <= 1'b0;
      r_signed   <= 1'b0;
      r_size     <= 2'b00;
      r_addr     <= 32'd0;
      r_wdata    <= 32'd0;
      word_reg   <= 32'd0;
      resp_rdata <= 32'd0;
      resp_fault <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          resp_rdata <= 32'd0;
          resp_fault <= 1'b0;
          if (hs) begin
            r_write  <= req_write;
            r_signed <= req_signed;
            r_size   <= req_size;
            r_addr   <= req_addr;
            r_wdata  <= req_wdata;
            if (fault) begin
              state      <= RESP;
              resp_fault <= 1'b1;
            end else if (req_write && req_size == 2'b10) begin
              state <= WRITE;
            end else begin
              state <= READ;
            end
          end
        end
        READ: begin
          word_reg <= mem_read_data;
          if (r_write) begin
            state <= WRITE;
          end else begin
            state      <= RESP;
            resp_rdata <= ld_ext;
          end
        end
        WRITE: state <= RESP;
        default: begin
          state      <= IDLE;
          resp_rdata <= 32'd0;
          resp_fault <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: a word-array memory model, a negedge response monitor
// and a request driver that queues expected fault/data/latency at each accept.
module tb_load_store_unit;
  logic        clk = 1'b0;
  logic        reset, req_valid, req_write, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        req_ready, resp_valid, resp_fault, mem_memwrite;
  logic [31:0] resp_rdata, mem_address, mem_write_data, mem_read_data;

  load_store_unit #(.MEM_BYTES(1024)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .resp_fault(resp_fault), .mem_address(mem_address),
    .mem_write_data(mem_write_data), .mem_memwrite(mem_memwrite),
    .mem_read_data(mem_read_data)
  );

  always #5 clk = ~clk;

  typedef struct { logic fault; logic [31:0] rdata; int lat; int acc; } exp_t;
  exp_t q[$];
  int errs = 0, checks = 0, cyc = 0;
  int wcnt = 0, nresp = 0, last_resp_cyc = 0, acc_cyc = 0;
  logic [31:0] last_wdata = 32'd0, last_waddr = 32'd0;
  logic mem_load;
  logic [31:0] mem [256];

  assign mem_read_data = mem[mem_address[9:2]];
  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'd0;
      mem[4]   <= 32'h8899AABB;
      mem[8]   <= 32'h11223344;
      mem[255] <= 32'hCAFEF00D;
    end else if (mem_memwrite) begin
      mem[mem_address[9:2]] <= mem_write_data;
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mem_memwrite) begin
      wcnt++;
      last_wdata = mem_write_data;
      last_waddr = mem_address;
    end
    if (!reset && resp_valid) begin
      exp_t e;
      nresp++;
      last_resp_cyc = cyc;
      chk("ready_in_resp", {31'd0, req_ready}, 32'd0);
      if (q.size() == 0) begin
        chk("unexpected_resp", 32'd1, 32'd0);
      end else begin
        e = q.pop_front();
        chk("resp_fault", {31'd0, resp_fault}, {31'd0, e.fault});
        chk("resp_rdata", resp_rdata, e.rdata);
        chk("resp_latency", cyc - e.acc, e.lat);
      end
    end
  end

  task automatic issue(input logic w, input logic [1:0] sz, input logic sg, input logic [31:0] a,
                       input logic [31:0] wd, input logic ef, input logic [31:0] er,
                       input int el, input bit hold);
    bit done = 0;
    req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = wd;
    for (int n = 0; n < 30 && !done; n++) begin
      if (req_ready) begin
        acc_cyc = cyc;
        q.push_back('{ef, er, el, cyc});
        done = 1;
      end
      @(posedge clk); #1;
    end
    if (!done) chk("accept_timeout", 32'd0, 32'd1);
    if (!hold || !done) req_valid = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 50 && q.size() != 0; n++) begin
      @(posedge clk); #1;
    end
    chk("drain", q.size(), 32'd0);
  endtask

  initial begin
    int w0, r0;
    reset = 1'b1; mem_load = 1'b1; req_valid = 1'b0; req_write = 1'b0;
    req_size = 2'b00; req_signed = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_memwrite", {31'd0, mem_memwrite}, 32'd0);
    chk("rst_mem_addr", mem_address, 32'd0);
    chk("rst_ready", {31'd0, req_ready}, 32'd0);
    reset = 1'b0; mem_load = 1'b0;
    #1 chk("ready_after_rst", {31'd0, req_ready}, 32'd1);

    // loads with sign/zero extension
    w0 = wcnt;
    issue(0, 2'b00, 1, 32'h11, 32'h0, 0, 32'hFFFFFF99, 2, 0);
    issue(0, 2'b00, 0, 32'h13, 32'h0, 0, 32'h000000BB, 2, 0);
    issue(0, 2'b01, 1, 32'h12, 32'h0, 0, 32'hFFFFAABB, 2, 0);
    issue(0, 2'b01, 0, 32'h10, 32'h0, 0, 32'h00008899, 2, 0);
    issue(0, 2'b10, 1, 32'h10, 32'h0, 0, 32'h8899AABB, 2, 0);
    drain();
    chk("loads_no_write", wcnt - w0, 32'd0);

    // sub-word and word stores
    w0 = wcnt;
    issue(1, 2'b00, 0, 32'h12, 32'h12345655, 0, 32'h0, 3, 0);
    drain();
    chk("sb_write_cycles", wcnt - w0, 32'd1);
    chk("sb_wdata", last_wdata, 32'h889955BB);
    chk("sb_waddr", last_waddr, 32'h10);
    chk("idle_mem_addr", mem_address, 32'd0);
    issue(0, 2'b10, 0, 32'h10, 32'h0, 0, 32'h889955BB, 2, 0);
    issue(1, 2'b01, 1, 32'h14, 32'hFFFFBEEF, 0, 32'h0, 3, 0);
    issue(0, 2'b10, 0, 32'h14, 32'h0, 0, 32'hBEEF0000, 2, 0);
    issue(1, 2'b10, 0, 32'h18, 32'h01020304, 0, 32'h0, 2, 0);
    issue(0, 2'b00, 1, 32'h1B, 32'h0, 0, 32'h00000004, 2, 0);
    drain();

    // faults and range boundary
    w0 = wcnt;
    issue(1, 2'b01, 0, 32'h11, 32'hFFFF, 1, 32'h0, 1, 0);
    issue(0, 2'b10, 0, 32'h3FE, 32'h0, 1, 32'h0, 1, 0);
    issue(0, 2'b10, 0, 32'h3FC, 32'h0, 0, 32'hCAFEF00D, 2, 0);
    issue(0, 2'b00, 0, 32'h400, 32'h0, 1, 32'h0, 1, 0);
    issue(0, 2'b11, 0, 32'h0, 32'h0, 1, 32'h0, 1, 0);
    issue(1, 2'b00, 0, 32'hFFFFFFFF, 32'h0, 1, 32'h0, 1, 0);
    drain();
    chk("fault_no_write", wcnt - w0, 32'd0);

    // reset during the WRITE cycle of a word store
    w0 = wcnt; r0 = nresp;
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b10; req_addr = 32'h20; req_wdata = 32'hDEADBEEF;
    chk("sw_ready", {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    reset = 1'b1;
    #1 chk("rst_kills_write", {31'd0, mem_memwrite}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    #1 chk("ready_after_abort", {31'd0, req_ready}, 32'd1);
    repeat (4) @(posedge clk);
    #1;
    chk("mem20_unchanged", mem[8], 32'h11223344);
    chk("abort_no_write", wcnt - w0, 32'd0);
    chk("abort_no_resp", nresp - r0, 32'd0);

    // back-to-back with req_valid held high
    issue(0, 2'b10, 0, 32'h10, 32'h0, 0, 32'h889955BB, 2, 1);
    chk("ready_in_read", {31'd0, req_ready}, 32'd0);
    issue(0, 2'b10, 0, 32'h3FC, 32'h0, 0, 32'hCAFEF00D, 2, 0);
    chk("b2b_accept_cycle", acc_cyc, last_resp_cyc + 1);
    drain();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
